// File: rtl/ibex_rvfi_pkg.sv
// Shared types for the RVFI retirement trace FIFO.
// rvfi_rec_t packs every captured RVFI field of one retired instruction.
package ibex_rvfi_pkg;

  // One retirement record, MSB-first in field order.
  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic [31:0] pc_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } rvfi_rec_t;

  localparam int unsigned RvfiRecWidth = $bits(rvfi_rec_t);

  // Overflow counter sticks at this value instead of wrapping.
  localparam logic [15:0] RvfiOverflowMax = 16'hFFFF;

  // Saturating increment of the dropped-record counter.
  function automatic logic [15:0] rvfi_sat_inc(input logic [15:0] val);
    return (val == RvfiOverflowMax) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/ibex_rvfi_order_chk.sv
// Retirement order continuity checker.
// Tracks the order of the last record offered (pushed or dropped) and raises a
// sticky error when a later record does not follow it by exactly one.
// Only instantiated when RVFI_ORDER_CHECK_EN is defined.
module ibex_rvfi_order_chk (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [63:0] order_i,
  output logic        order_err_o
);

  logic        seeded_q, seeded_d;
  logic [63:0] last_q, last_d;
  logic        err_q, err_d;

  // Next-state: first record after reset only seeds the reference.
  always_comb begin
    seeded_d = seeded_q;
    last_d   = last_q;
    err_d    = err_q;
    if (valid_i) begin
      if (seeded_q && (order_i != last_q + 64'd1)) begin
        err_d = 1'b1;
      end
      last_d   = order_i;
      seeded_d = 1'b1;
    end
  end

  // Reference order and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seeded_q <= 1'b0;
      last_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      seeded_q <= seeded_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign order_err_o = err_q;

endmodule

// File: rtl/ibex_rvfi_trace_fifo.sv
// RVFI retirement trace FIFO with show-ahead output.
// Captures every RVFI retirement into a flop-array FIFO. When full, a push is
// only accepted if the head is popped in the same cycle; otherwise the record
// is dropped and a saturating overflow counter increments.
// Optional feature: define RVFI_ORDER_CHECK_EN to enable the order continuity
// checker (ibex_rvfi_order_chk); otherwise order_err_o is tied low.
module ibex_rvfi_trace_fifo
  import ibex_rvfi_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rvfi_valid_i,
  input  logic [63:0]              rvfi_order_i,
  input  logic [31:0]              rvfi_insn_i,
  input  logic                     rvfi_trap_i,
  input  logic                     rvfi_intr_i,
  input  logic [31:0]              rvfi_pc_rdata_i,
  input  logic [4:0]               rvfi_rd_addr_i,
  input  logic [31:0]              rvfi_rd_wdata_i,
  input  logic [31:0]              rvfi_mem_addr_i,
  input  logic [3:0]               rvfi_mem_rmask_i,
  input  logic [3:0]               rvfi_mem_wmask_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output rvfi_rec_t                out_rec_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [15:0]              overflow_cnt_o,
  output logic                     order_err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

  rvfi_rec_t       mem_q [Depth];
  rvfi_rec_t       in_rec;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [15:0]     ovf_q, ovf_d;
  logic            full, empty;
  logic            push, pop, drop;

  // Pack the incoming retirement into one record.
  always_comb begin
    in_rec           = '0;
    in_rec.order     = rvfi_order_i;
    in_rec.insn      = rvfi_insn_i;
    in_rec.trap      = rvfi_trap_i;
    in_rec.intr      = rvfi_intr_i;
    in_rec.pc_rdata  = rvfi_pc_rdata_i;
    in_rec.rd_addr   = rvfi_rd_addr_i;
    in_rec.rd_wdata  = rvfi_rd_wdata_i;
    in_rec.mem_addr  = rvfi_mem_addr_i;
    in_rec.mem_rmask = rvfi_mem_rmask_i;
    in_rec.mem_wmask = rvfi_mem_wmask_i;
  end

  // Handshake decode: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    full  = (level_q == LvlFull);
    empty = (level_q == '0);
    pop   = !empty && out_ready_i;
    push  = rvfi_valid_i && (!full || pop);
    drop  = rvfi_valid_i && full && !pop;
  end

  // Next-state for pointers, occupancy and overflow count.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    // Depth is a power of two, so natural pointer overflow is the modulo wrap.
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      ovf_d = rvfi_sat_inc(ovf_q);
    end
  end

  // Control state; reset empties the FIFO at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Record storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= in_rec;
    end
  end

  // Show-ahead output straight from registered state.
  assign out_valid_o    = !empty;
  assign out_rec_o      = mem_q[rptr_q];
  assign level_o        = level_q;
  assign overflow_cnt_o = ovf_q;

`ifdef RVFI_ORDER_CHECK_EN
  // Every offered record (accepted or dropped) advances the order reference.
  ibex_rvfi_order_chk u_order_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (rvfi_valid_i),
    .order_i     (rvfi_order_i),
    .order_err_o (order_err_o)
  );
`else
  assign order_err_o = 1'b0;
`endif

endmodule
